simple_pipe_param: RTL and testbench
====================================

Name: simple_pipe_param

Overview:
Parametrised three-stage in-order pipeline (ID | EX | WB) executing NOP/ADD/SET/NAND on an NREG-entry, DW-bit register file, with scoreboard-driven forwarding and per-stage ready/valid interlocking. Generalises the fixed 8-bit/4-register pipeline to arbitrary data width and register count. Adds a pipeline flush, a defined register-file reset, and a retire port for the ILA refinement/instruction recorder. The instruction arrives directly on an input; there is no fetch.

Parameters:
DW, 8, datapath/register width (>= 2*RW)
NREG, 4, number of architectural registers (power of 2, >= 2)
RW, $clog2(NREG), register index width (derived, localparam)
IW, 2+3*RW, instruction width (derived, localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
inst  in  IW  {op[1:0], rs1, rs2, rd}; SET uses {op, imm[2*RW-1:0], rd}
inst_valid  in  1  instruction present
inst_ready  out  1  ID accepts this cycle
stallex  in  1  force EX not-ready
stallwb  in  1  force WB not-ready
flush  in  1  squash all in-flight instructions
retire_valid  out  1  WB completes an instruction this cycle
retire_wen  out  1  retiring instruction writes RF
retire_rd  out  RW  destination of retiring instruction
retire_data  out  DW  value written
retire_inst  out  IW  retiring instruction encoding
dbg_rf_idx  in  RW  debug read index
dbg_rf_data  out  DW  registers[dbg_rf_idx], combinational

Behaviour:
- Ops: NOP=00 (no write; ALU result 0), ADD=01 (rs1+rs2 mod 2^DW), SET=10 (imm zero-extended to DW), NAND=11 (~(rs1&rs2)).
- Handshakes:
  - id_go = inst_valid & inst_ready.
  - inst_ready = !flush & (ex_ready | !id_ex_valid).
  - ex_ready = !stallex & (!stallwb | !ex_wb_valid).
  - ex_go = id_ex_valid & ex_ready & !flush.
  - wb_go = ex_wb_valid & !stallwb & !flush.
- Valid bits: id_ex_valid cleared by ex_go without id_go; ex_wb_valid cleared by wb_go without ex_go. Payload registers load only on their go.
- Latency: accepted at cycle t -> EX at t+1 -> WB/retire at t+2 with no stalls; RF write at the end of t+2; visible on dbg_rf_data at t+3. Each stall cycle adds one.
- Throughput: one instruction per cycle with no stalls; back-to-back dependent instructions never stall (full forwarding).
- Scoreboard, 2 bits per register:
  - bit1 = pending in EX: set on id_go for rd when op!=NOP, cleared on ex_go.
  - bit0 = pending in WB: set on ex_go for rd when the EX instruction writes, cleared on wb_go.
  - Set has priority over clear in the same cycle.
- Operand select: bit1 -> EX ALU result; else bit0 -> ex_wb_val; else RF.
- Invariant (assertion): bit1[r] == id_ex_valid & id_ex_wen & id_ex_rd==r; bit0[r] == ex_wb_valid & ex_wb_wen & ex_wb_rd==r.
- Flush: that cycle both valids and all scoreboard bits clear to 0, no RF write, no retire, inst_ready=0. Flush overrides all go signals. RF contents are unchanged.
- Retire port: combinational from the WB stage, qualified by wb_go; retire_wen = ex_wb_wen.
- Reset:
  - valids, scoreboard and all RF entries cleared to 0.
  - retire_* outputs are 0 when retire_valid=0.
  - inst_ready is 1 in the first cycle after reset.
  - Reset mid-operation discards in-flight work with no retire.
- A register written in WB and read in ID in the same cycle is forwarded from ex_wb_val, never read stale from the RF.

Decomposition:
- simple_pipe_pkg: op encodings (OP_NOP/ADD/SET/NAND), function alu(op,a,b) parametrised on DW.
- Sub-module simple_pipe_scoreboard: NREG x 2 bit state, set/clear/flush inputs, per-register read for rs1/rs2.

Test Plan:
- Forwarding from EX and WB (DW=8, NREG=4): SET r1=5 (0x95), ADD r2=r1+r1 (0x56), NAND r3=~(r2&r1) (0xE7) on consecutive cycles -> retires r1=0x05, r2=0x0A, r3=0xFF on t+2..t+4; no ready deassertion.
- stallwb held 3 cycles with two instructions in flight: inst_ready=0, no retire during the stall; retire order and values preserved after release; scoreboard invariant holds every cycle.
- stallex for 1 cycle between SET r0=3 and ADD r1=r0+r0 -> r1=6 retires one cycle later than unstalled.
- flush with SET r2=7 in EX and SET r3=9 in WB -> no retire, r2/r3 keep prior values, scoreboard all 0; next ADD r1=r2+r3 reads RF values.
- Reset asserted mid-stream -> the next cycle has valids=0, all RF entries=0, inst_ready=1, no retire.
- Parameter sweep DW=16, NREG=8 (IW=11): SET r7=0x3F then ADD r6=r7+r7 -> r6=0x007E; ADD with r7=0xFFFF+1 wraps to 0x0000.

Source files
------------

// File: rtl/simple_pipe_pkg.sv
// Shared opcode encodings and the width-generic ALU used by the ID|EX|WB pipeline.
package simple_pipe_pkg;

    localparam int ALU_MAX_W = 64;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_ADD  = 2'b01,
        OP_SET  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    // Operands arrive zero-extended to ALU_MAX_W; the result is masked to dw bits.
    function automatic logic [ALU_MAX_W-1:0] alu(
        input op_t                  op,
        input logic [ALU_MAX_W-1:0] a,
        input logic [ALU_MAX_W-1:0] b,
        input int                   dw
    );
        logic [ALU_MAX_W-1:0] mask;
        logic [ALU_MAX_W-1:0] res;
        mask = (dw >= ALU_MAX_W) ? '1 : ((ALU_MAX_W'(1) << dw) - ALU_MAX_W'(1));
        case (op)
            OP_ADD:  res = a + b;
            OP_SET:  res = b;
            OP_NAND: res = ~(a & b);
            default: res = '0;
        endcase
        return res & mask;
    endfunction

endpackage

// File: rtl/simple_pipe_scoreboard.sv
// Two pending bits per register: bit1 = producer sits in EX, bit0 = producer sits in WB.
module simple_pipe_scoreboard
    import simple_pipe_pkg::*;
#(
    parameter  int NREG = 4,
    localparam int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            ex_set,
    input  logic [RW-1:0]   ex_set_idx,
    input  logic            ex_clr,
    input  logic [RW-1:0]   ex_clr_idx,
    input  logic            wb_set,
    input  logic [RW-1:0]   wb_set_idx,
    input  logic            wb_clr,
    input  logic [RW-1:0]   wb_clr_idx,
    input  logic [RW-1:0]   rs1_idx,
    input  logic [RW-1:0]   rs2_idx,
    output logic [1:0]      rs1_pend,
    output logic [1:0]      rs2_pend,
    output logic [NREG-1:0] pend_ex,
    output logic [NREG-1:0] pend_wb
);

    // A set and a clear hitting the same register in one cycle leaves the bit set.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pend_ex <= '0;
            pend_wb <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (ex_set && ex_set_idx == RW'(r))
                    pend_ex[r] <= 1'b1;
                else if (ex_clr && ex_clr_idx == RW'(r))
                    pend_ex[r] <= 1'b0;

                if (wb_set && wb_set_idx == RW'(r))
                    pend_wb[r] <= 1'b1;
                else if (wb_clr && wb_clr_idx == RW'(r))
                    pend_wb[r] <= 1'b0;
            end
        end
    end

    assign rs1_pend = {pend_ex[rs1_idx], pend_wb[rs1_idx]};
    assign rs2_pend = {pend_ex[rs2_idx], pend_wb[rs2_idx]};

endmodule

// File: rtl/simple_pipe_param.sv
// Parametrised three-stage in-order pipeline (ID | EX | WB) with full forwarding,
// ready/valid interlocks, flush and a retire port for the instruction recorder.
module simple_pipe_param
    import simple_pipe_pkg::*;
#(
    parameter  int DW   = 8,
    parameter  int NREG = 4,
    localparam int RW   = $clog2(NREG),
    localparam int IW   = 2 + 3 * RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] inst,
    input  logic          inst_valid,
    output logic          inst_ready,
    input  logic          stallex,
    input  logic          stallwb,
    input  logic          flush,
    output logic          retire_valid,
    output logic          retire_wen,
    output logic [RW-1:0] retire_rd,
    output logic [DW-1:0] retire_data,
    output logic [IW-1:0] retire_inst,
    input  logic [RW-1:0] dbg_rf_idx,
    output logic [DW-1:0] dbg_rf_data
);

    logic [DW-1:0] rf [NREG];

    op_t             inst_op;
    logic [RW-1:0]   inst_rs1;
    logic [RW-1:0]   inst_rs2;
    logic [RW-1:0]   inst_rd;
    logic [2*RW-1:0] inst_imm;

    logic          id_ex_valid;
    op_t           id_ex_op;
    logic [DW-1:0] id_ex_a;
    logic [DW-1:0] id_ex_b;
    logic [RW-1:0] id_ex_rd;
    logic          id_ex_wen;
    logic [IW-1:0] id_ex_inst;

    logic          ex_wb_valid;
    logic [DW-1:0] ex_wb_val;
    logic [RW-1:0] ex_wb_rd;
    logic          ex_wb_wen;
    logic [IW-1:0] ex_wb_inst;

    logic id_go;
    logic ex_go;
    logic wb_go;
    logic ex_ready;

    logic [DW-1:0]   ex_result;
    logic [DW-1:0]   rs1_val;
    logic [DW-1:0]   rs2_val;
    logic [1:0]      rs1_pend;
    logic [1:0]      rs2_pend;
    logic [NREG-1:0] sb_ex;
    logic [NREG-1:0] sb_wb;

    assign inst_op  = op_t'(inst[IW-1 -: 2]);
    assign inst_rs1 = inst[3*RW-1 -: RW];
    assign inst_rs2 = inst[2*RW-1 -: RW];
    assign inst_rd  = inst[RW-1:0];
    assign inst_imm = inst[3*RW-1 -: 2*RW];

    assign ex_ready   = ~stallex & (~stallwb | ~ex_wb_valid);
    assign inst_ready = ~flush & (ex_ready | ~id_ex_valid);
    assign id_go      = inst_valid & inst_ready;
    assign ex_go      = id_ex_valid & ex_ready & ~flush;
    assign wb_go      = ex_wb_valid & ~stallwb & ~flush;

    assign ex_result = DW'(alu(id_ex_op, ALU_MAX_W'(id_ex_a), ALU_MAX_W'(id_ex_b), DW));

    simple_pipe_scoreboard #(.NREG(NREG)) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .ex_set     (id_go & (inst_op != OP_NOP)),
        .ex_set_idx (inst_rd),
        .ex_clr     (ex_go),
        .ex_clr_idx (id_ex_rd),
        .wb_set     (ex_go & id_ex_wen),
        .wb_set_idx (id_ex_rd),
        .wb_clr     (wb_go),
        .wb_clr_idx (ex_wb_rd),
        .rs1_idx    (inst_rs1),
        .rs2_idx    (inst_rs2),
        .rs1_pend   (rs1_pend),
        .rs2_pend   (rs2_pend),
        .pend_ex    (sb_ex),
        .pend_wb    (sb_wb)
    );

    // The youngest producer wins: EX result first, then the WB value, then the RF.
    always_comb begin
        rs1_val = rf[inst_rs1];
        if (rs1_pend[1])
            rs1_val = ex_result;
        else if (rs1_pend[0])
            rs1_val = ex_wb_val;

        rs2_val = rf[inst_rs2];
        if (rs2_pend[1])
            rs2_val = ex_result;
        else if (rs2_pend[0])
            rs2_val = ex_wb_val;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            id_ex_valid <= 1'b0;
            ex_wb_valid <= 1'b0;
        end else begin
            if (id_go)
                id_ex_valid <= 1'b1;
            else if (ex_go)
                id_ex_valid <= 1'b0;

            if (ex_go)
                ex_wb_valid <= 1'b1;
            else if (wb_go)
                ex_wb_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (id_go) begin
            id_ex_op   <= inst_op;
            id_ex_a    <= rs1_val;
            id_ex_b    <= (inst_op == OP_SET) ? DW'(inst_imm) : rs2_val;
            id_ex_rd   <= inst_rd;
            id_ex_wen  <= (inst_op != OP_NOP);
            id_ex_inst <= inst;
        end
        if (ex_go) begin
            ex_wb_val  <= ex_result;
            ex_wb_rd   <= id_ex_rd;
            ex_wb_wen  <= id_ex_wen;
            ex_wb_inst <= id_ex_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                rf[r] <= '0;
        end else if (wb_go && ex_wb_wen) begin
            rf[ex_wb_rd] <= ex_wb_val;
        end
    end

    // Reset in the same cycle as a WB completion discards it, so nothing retires.
    assign retire_valid = wb_go & ~rst;
    assign retire_wen   = retire_valid & ex_wb_wen;
    assign retire_rd    = retire_valid ? ex_wb_rd   : '0;
    assign retire_data  = retire_valid ? ex_wb_val  : '0;
    assign retire_inst  = retire_valid ? ex_wb_inst : '0;

    assign dbg_rf_data = rf[dbg_rf_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                assert (sb_ex[r] == (id_ex_valid && id_ex_wen && (id_ex_rd == RW'(r))));
                assert (sb_wb[r] == (ex_wb_valid && ex_wb_wen && (ex_wb_rd == RW'(r))));
            end
        end
    end

endmodule

// File: tb/tb_simple_pipe_param.sv
// Bench for simple_pipe_param: directed and random traffic against an in-order
// architectural model, plus a DW=16/NREG=8 instance for the parameter sweep.
module tb_simple_pipe_param;

    logic       clk;
    logic       rst;
    logic [7:0] inst;
    logic       inst_valid;
    logic       inst_ready;
    logic       stallex;
    logic       stallwb;
    logic       flush;
    logic       retire_valid;
    logic       retire_wen;
    logic [1:0] retire_rd;
    logic [7:0] retire_data;
    logic [7:0] retire_inst;
    logic [1:0] dbg_rf_idx;
    logic [7:0] dbg_rf_data;

    logic [10:0] s_inst;
    logic        s_inst_valid;
    logic        s_inst_ready;
    logic        s_retire_valid;
    logic        s_retire_wen;
    logic [2:0]  s_retire_rd;
    logic [15:0] s_retire_data;
    logic [10:0] s_retire_inst;
    logic [2:0]  s_dbg_idx;
    logic [15:0] s_dbg_data;

    simple_pipe_param #(.DW(8), .NREG(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .stallex      (stallex),
        .stallwb      (stallwb),
        .flush        (flush),
        .retire_valid (retire_valid),
        .retire_wen   (retire_wen),
        .retire_rd    (retire_rd),
        .retire_data  (retire_data),
        .retire_inst  (retire_inst),
        .dbg_rf_idx   (dbg_rf_idx),
        .dbg_rf_data  (dbg_rf_data)
    );

    simple_pipe_param #(.DW(16), .NREG(8)) dut_wide (
        .clk          (clk),
        .rst          (rst),
        .inst         (s_inst),
        .inst_valid   (s_inst_valid),
        .inst_ready   (s_inst_ready),
        .stallex      (1'b0),
        .stallwb      (1'b0),
        .flush        (1'b0),
        .retire_valid (s_retire_valid),
        .retire_wen   (s_retire_wen),
        .retire_rd    (s_retire_rd),
        .retire_data  (s_retire_data),
        .retire_inst  (s_retire_inst),
        .dbg_rf_idx   (s_dbg_idx),
        .dbg_rf_data  (s_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] inst;
        int         rd;
        bit         wen;
        int         data;
        bit         at_wb;
    } rec_t;

    rec_t inflight[$];
    int   spec_rf[4];
    int   commit_rf[4];
    int   vectors     = 0;
    int   miscompares = 0;
    int   dbg_sel     = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Program-order semantics: each instruction sees every earlier accepted one.
    function automatic rec_t refExec(input logic [7:0] i);
        rec_t r;
        int   a;
        int   b;
        int   op;
        op      = int'(i[7:6]);
        a       = spec_rf[i[5:4]];
        b       = spec_rf[i[3:2]];
        r.inst  = i;
        r.rd    = int'(i[1:0]);
        r.wen   = (op != 0);
        r.at_wb = 1'b0;
        case (op)
            1:       r.data = (a + b) % 256;
            2:       r.data = int'(i[5:2]);
            3:       r.data = 255 - (a & b);
            default: r.data = 0;
        endcase
        return r;
    endfunction

    task automatic applyStimulus(input logic v, input logic [7:0] i,
                                 input logic sx, input logic sw, input logic fl);
        bit   wb_occ;
        bit   ex_occ;
        bit   ret;
        bit   ex_move;
        bit   rdy;
        rec_t r;
        rec_t n;
        @(negedge clk);
        rst        = 1'b0;
        inst_valid = v;
        inst       = i;
        stallex    = sx;
        stallwb    = sw;
        flush      = fl;
        dbg_rf_idx = 2'(dbg_sel);
        #2;
        wb_occ  = (inflight.size() > 0) && inflight[0].at_wb;
        ex_occ  = inflight.size() > (wb_occ ? 1 : 0);
        ret     = wb_occ && !sw && !fl;
        ex_move = ex_occ && !sx && (!wb_occ || !sw) && !fl;
        rdy     = !fl && (!ex_occ || ex_move);

        checkOutput("inst_ready", 32'(inst_ready), 32'(rdy));
        checkOutput("retire_valid", 32'(retire_valid), 32'(ret));
        if (ret) begin
            r = inflight[0];
            checkOutput("retire_rd", 32'(retire_rd), 32'(r.rd));
            checkOutput("retire_wen", 32'(retire_wen), 32'(r.wen));
            checkOutput("retire_data", 32'(retire_data), 32'(r.data));
            checkOutput("retire_inst", 32'(retire_inst), 32'(r.inst));
        end else begin
            checkOutput("retire_data_idle", 32'(retire_data), 32'd0);
        end
        checkOutput("dbg_rf_data", 32'(dbg_rf_data), 32'(commit_rf[dbg_sel]));

        @(posedge clk);
        if (fl) begin
            inflight.delete();
            spec_rf = commit_rf;
        end else begin
            if (ret) begin
                if (r.wen)
                    commit_rf[r.rd] = r.data;
                void'(inflight.pop_front());
            end
            if (ex_move) begin
                n = inflight[0];
                n.at_wb = 1'b1;
                inflight[0] = n;
            end
            if (v && rdy) begin
                n = refExec(i);
                if (n.wen)
                    spec_rf[n.rd] = n.data;
                inflight.push_back(n);
            end
        end
    endtask

    task automatic applyReset(input logic v, input logic [7:0] i);
        @(negedge clk);
        rst        = 1'b1;
        inst_valid = v;
        inst       = i;
        stallex    = 1'b0;
        stallwb    = 1'b0;
        flush      = 1'b0;
        @(posedge clk);
        inflight.delete();
        for (int k = 0; k < 4; k++) begin
            spec_rf[k]   = 0;
            commit_rf[k] = 0;
        end
    endtask

    task automatic checkReg(input string tag, input int idx, input logic [31:0] exp);
        dbg_sel = idx;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput(tag, 32'(dbg_rf_data), exp);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    logic [10:0] prog [5];
    logic [15:0] wexp [5];
    logic [2:0]  wrd  [5];

    initial begin
        rst          = 1'b1;
        inst         = '0;
        inst_valid   = 1'b0;
        stallex      = 1'b0;
        stallwb      = 1'b0;
        flush        = 1'b0;
        dbg_rf_idx   = '0;
        s_inst       = '0;
        s_inst_valid = 1'b0;
        s_dbg_idx    = '0;

        applyReset(1'b0, 8'h00);
        applyReset(1'b0, 8'h00);
        for (int k = 0; k < 4; k++)
            checkReg("reset_rf", k, 32'd0);
        checkOutput("reset_ready", 32'(inst_ready), 32'd1);

        // SET r1=5; ADD r2=r1+r1; NAND r3=~(r2&r1) back to back
        applyStimulus(1'b1, 8'h95, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h56, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hE7, 1'b0, 1'b0, 1'b0);
        idle(3);
        checkReg("fwd_r1", 1, 32'h05);
        checkReg("fwd_r2", 2, 32'h0A);
        checkReg("fwd_r3", 3, 32'hFF);

        // SET r0=3; ADD r1=r0+r0; ADD r2=r1+r0 held while WB stalls 3 cycles
        applyStimulus(1'b1, 8'h8C, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, 8'h52, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h52, 1'b0, 1'b0, 1'b0);
        idle(3);
        checkReg("stallwb_r1", 1, 32'h06);
        checkReg("stallwb_r2", 2, 32'h09);

        // SET r0=4; ADD r1=r0+r0 with one stallex cycle
        applyStimulus(1'b1, 8'h90, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        idle(3);
        checkReg("stallex_r1", 1, 32'h08);

        // SET r3=9 reaches WB, SET r2=7 reaches EX, then flush; ADD r0=r2+r3
        applyStimulus(1'b1, 8'hA7, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h9E, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h6C, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h6C, 1'b0, 1'b0, 1'b0);
        idle(3);
        checkReg("flush_r2", 2, 32'h09);
        checkReg("flush_r3", 3, 32'hFF);
        checkReg("flush_r0", 0, 32'h08);

        applyStimulus(1'b1, 8'h95, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h56, 1'b0, 1'b0, 1'b0);
        applyReset(1'b1, 8'hE7);
        #1;
        checkOutput("midreset_ready", 32'(inst_ready), 32'd1);
        for (int k = 0; k < 4; k++)
            checkReg("midreset_rf", k, 32'd0);

        for (int k = 0; k < 400; k++) begin
            dbg_sel = int'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom),
                          $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                          $urandom_range(0, 29) == 0);
        end
        idle(4);

        prog[0] = {2'b10, 6'h3F, 3'd7};
        prog[1] = {2'b01, 3'd7, 3'd7, 3'd6};
        prog[2] = {2'b11, 3'd0, 3'd0, 3'd7};
        prog[3] = {2'b10, 6'd1, 3'd5};
        prog[4] = {2'b01, 3'd7, 3'd5, 3'd4};
        wexp[0] = 16'h003F; wrd[0] = 3'd7;
        wexp[1] = 16'h007E; wrd[1] = 3'd6;
        wexp[2] = 16'hFFFF; wrd[2] = 3'd7;
        wexp[3] = 16'h0001; wrd[3] = 3'd5;
        wexp[4] = 16'h0000; wrd[4] = 3'd4;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            s_inst_valid = (k < 5);
            if (k < 5)
                s_inst = prog[k];
            else
                s_inst = '0;
            #2;
            checkOutput("wide_ready", 32'(s_inst_ready), 32'd1);
            if (k >= 2 && k <= 6) begin
                checkOutput("wide_retire_valid", 32'(s_retire_valid), 32'd1);
                checkOutput("wide_retire_rd", 32'(s_retire_rd), 32'(wrd[k-2]));
                checkOutput("wide_retire_data", 32'(s_retire_data), 32'(wexp[k-2]));
                checkOutput("wide_retire_inst", 32'(s_retire_inst), 32'(prog[k-2]));
            end else begin
                checkOutput("wide_retire_valid", 32'(s_retire_valid), 32'd0);
            end
        end
        @(negedge clk); s_dbg_idx = 3'd6; #2;
        checkOutput("wide_r6", 32'(s_dbg_data), 32'h007E);
        @(negedge clk); s_dbg_idx = 3'd4; #2;
        checkOutput("wide_r4_wrap", 32'(s_dbg_data), 32'h0000);
        @(negedge clk); s_dbg_idx = 3'd7; #2;
        checkOutput("wide_r7", 32'(s_dbg_data), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
